// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending controller family.
package vend_pkg;

    localparam int unsigned PENNY   = 1;
    localparam int unsigned NICKEL  = 5;
    localparam int unsigned DIME    = 10;
    localparam int unsigned QUARTER = 25;

    typedef enum logic [1:0] {
        COIN_PENNY   = 2'd0,
        COIN_NICKEL  = 2'd1,
        COIN_DIME    = 2'd2,
        COIN_QUARTER = 2'd3
    } coin_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_BAD_PRODUCT = 3'd1,
        ERR_SOLD_OUT    = 3'd2,
        ERR_NO_CREDIT   = 3'd3,
        ERR_BUSY        = 3'd4,
        ERR_COIN_REJECT = 3'd5
    } err_t;

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } state_t;

    function automatic logic [4:0] coin_value(input coin_t c);
        case (c)
            COIN_PENNY:   coin_value = 5'(PENNY);
            COIN_NICKEL:  coin_value = 5'(NICKEL);
            COIN_DIME:    coin_value = 5'(DIME);
            default:      coin_value = 5'(QUARTER);
        endcase
    endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change selector: picks the largest coin not exceeding credit and
// returns the decremented credit.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] credit,
    input  logic          en,
    output logic          coin_valid,
    output coin_t         coin,
    output logic [CW-1:0] credit_next,
    output logic          done
);

    always_comb begin
        if (credit >= CW'(QUARTER)) begin
            coin = COIN_QUARTER;
        end else if (credit >= CW'(DIME)) begin
            coin = COIN_DIME;
        end else if (credit >= CW'(NICKEL)) begin
            coin = COIN_NICKEL;
        end else begin
            coin = COIN_PENNY;
        end
        coin_valid  = en && (credit != '0);
        credit_next = coin_valid ? credit - CW'(coin_value(coin)) : credit;
        done        = coin_valid && (credit_next == '0);
    end

endmodule

// File: rtl/vend_controller_p.sv
// Parametrised vending controller: credit accumulation, per-product stock,
// coded errors, greedy refund and restock.
module vend_controller_p
    import vend_pkg::*;
#(
    parameter int unsigned              N_PROD     = 4,
    parameter int unsigned              CW         = 8,
    parameter logic [N_PROD*CW-1:0]     PRICES     = {8'd100, 8'd75, 8'd50, 8'd65},
    parameter int unsigned              STOCK_W    = 4,
    parameter int unsigned              STOCK_INIT = 5,
    parameter int unsigned              MAX_CREDIT = 200
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      coin_valid,
    input  logic [1:0]                coin_type,
    input  logic                      buy,
    input  logic [$clog2(N_PROD)-1:0] product,
    input  logic                      cancel,
    input  logic                      restock,
    output logic                      vend_valid,
    output logic [$clog2(N_PROD)-1:0] vend_product,
    output logic                      error,
    output logic [2:0]                err_code,
    output logic [CW-1:0]             credit,
    output logic                      change_valid,
    output logic [1:0]                change_coin,
    output logic                      busy
);

    localparam int unsigned PW = $clog2(N_PROD);
    localparam int unsigned EW = CW + 1;

    state_t              state_q, state_d;
    logic [CW-1:0]       credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q [N_PROD];
    logic [STOCK_W-1:0]  stock_d [N_PROD];
    logic                vend_valid_q, vend_valid_d;
    logic [PW-1:0]       vend_product_q, vend_product_d;
    logic                error_q, error_d;
    logic [2:0]          err_code_q, err_code_d;
    logic                change_valid_q, change_valid_d;
    logic [1:0]          change_coin_q, change_coin_d;

    logic [CW-1:0]       price_tab [N_PROD];
    logic [CW-1:0]       price;
    logic                prod_ok;
    logic [PW-1:0]       prod_idx;
    logic [EW-1:0]       coin_val;
    logic [EW-1:0]       base;
    logic [EW-1:0]       sum;
    logic                buy_ok;
    logic                ret_coin;
    logic                disp_en;
    err_t                err;

    logic                disp_valid;
    coin_t               disp_coin;
    logic [CW-1:0]       disp_credit;
    logic                disp_done;

    for (genvar g = 0; g < N_PROD; g++) begin : g_price
        assign price_tab[g] = PRICES[g*CW +: CW];
    end

    vend_change_dispenser #(.CW(CW)) u_disp (
        .credit      (credit_q),
        .en          (disp_en),
        .coin_valid  (disp_valid),
        .coin        (disp_coin),
        .credit_next (disp_credit),
        .done        (disp_done)
    );

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        stock_d        = stock_q;
        vend_valid_d   = 1'b0;
        vend_product_d = '0;
        change_valid_d = 1'b0;
        change_coin_d  = '0;
        err            = ERR_NONE;
        buy_ok         = 1'b0;
        ret_coin       = 1'b0;
        disp_en        = 1'b0;

        prod_ok  = 32'(product) < 32'(N_PROD);
        prod_idx = prod_ok ? product : '0;
        price    = price_tab[prod_idx];
        coin_val = EW'(coin_value(coin_t'(coin_type)));
        base     = EW'(credit_q);
        sum      = EW'(credit_q);

        case (state_q)
            IDLE: begin
                if (buy) begin
                    if (cancel)                          err = ERR_BUSY;
                    else if (!prod_ok)                   err = ERR_BAD_PRODUCT;
                    else if (stock_q[prod_idx] == '0)    err = ERR_SOLD_OUT;
                    else if (credit_q < price)           err = ERR_NO_CREDIT;
                    else                                 buy_ok = 1'b1;
                end
                // The coin ceiling is checked against credit after any price deduction.
                base = buy_ok ? EW'(credit_q) - EW'(price) : EW'(credit_q);
                sum  = base;
                if (coin_valid) begin
                    if (base + coin_val > EW'(MAX_CREDIT)) begin
                        ret_coin = 1'b1;
                        if (err == ERR_NONE) err = ERR_COIN_REJECT;
                    end else begin
                        sum = base + coin_val;
                    end
                end
                credit_d = CW'(sum);
                if (buy_ok) begin
                    vend_valid_d   = 1'b1;
                    vend_product_d = product;
                    if (!restock) stock_d[prod_idx] = stock_q[prod_idx] - STOCK_W'(1);
                end
                if (restock) begin
                    for (int unsigned i = 0; i < N_PROD; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
                end
                if (cancel && (sum != '0)) state_d = CHANGE;
            end
            CHANGE: begin
                if (buy) err = ERR_BUSY;
                if (coin_valid) begin
                    ret_coin = 1'b1;
                    if (err == ERR_NONE) err = ERR_COIN_REJECT;
                end else begin
                    disp_en  = 1'b1;
                    credit_d = disp_credit;
                    if (disp_done || !disp_valid) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ret_coin) begin
            change_valid_d = 1'b1;
            change_coin_d  = coin_type;
        end else if (disp_valid) begin
            change_valid_d = 1'b1;
            change_coin_d  = disp_coin;
        end
        error_d    = (err != ERR_NONE);
        err_code_d = err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            vend_valid_q   <= 1'b0;
            vend_product_q <= '0;
            error_q        <= 1'b0;
            err_code_q     <= '0;
            change_valid_q <= 1'b0;
            change_coin_q  <= '0;
            for (int unsigned i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_valid_q   <= vend_valid_d;
            vend_product_q <= vend_product_d;
            error_q        <= error_d;
            err_code_q     <= err_code_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
            stock_q        <= stock_d;
        end
    end

    assign vend_valid   = vend_valid_q;
    assign vend_product = vend_product_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign credit       = credit_q;
    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;
    assign busy         = (state_q == CHANGE);

endmodule

// File: tb/tb_vend_controller_p.sv
// Directed bench for vend_controller_p with a second 5-product instance for range checks.
module tb_vend_controller_p;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'd0;
    logic       buy = 1'b0;
    logic [1:0] product = 2'd0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic       vend_valid;
    logic [1:0] vend_product;
    logic       error;
    logic [2:0] err_code;
    logic [7:0] credit;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       busy;

    logic       b_coin_valid = 1'b0;
    logic [1:0] b_coin_type = 2'd0;
    logic       b_buy = 1'b0;
    logic [2:0] b_product = 3'd0;
    logic       b_vend_valid;
    logic [2:0] b_vend_product;
    logic       b_error;
    logic [2:0] b_err_code;
    logic [7:0] b_credit;
    logic       b_change_valid;
    logic [1:0] b_change_coin;
    logic       b_busy;
    logic       b_cancel = 1'b0;
    logic       b_restock = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vend_controller_p dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
        .buy(buy), .product(product), .cancel(cancel), .restock(restock),
        .vend_valid(vend_valid), .vend_product(vend_product), .error(error),
        .err_code(err_code), .credit(credit), .change_valid(change_valid),
        .change_coin(change_coin), .busy(busy)
    );

    vend_controller_p #(
        .N_PROD(5),
        .PRICES({8'd25, 8'd100, 8'd75, 8'd50, 8'd65})
    ) dut5 (
        .clk(clk), .reset(reset), .coin_valid(b_coin_valid), .coin_type(b_coin_type),
        .buy(b_buy), .product(b_product), .cancel(b_cancel), .restock(b_restock),
        .vend_valid(b_vend_valid), .vend_product(b_vend_product), .error(b_error),
        .err_code(b_err_code), .credit(b_credit), .change_valid(b_change_valid),
        .change_coin(b_change_coin), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid = 1'b0; buy = 1'b0; cancel = 1'b0; restock = 1'b0; reset = 1'b0;
        b_coin_valid = 1'b0; b_buy = 1'b0;
    endtask

    task automatic insert(input logic [1:0] t);
        coin_valid = 1'b1; coin_type = t;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (credit !== 8'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_credit_busy: got credit=%0d busy=%0d expected 0/0", credit, busy);
        end
        checks++;
        if ({vend_valid, error, change_valid} !== 3'b000 || {vend_product, err_code, change_coin} !== 7'd0) begin
            errors++; $display("FAIL reset_outputs: got vv=%0b err=%0b cv=%0b vp=%0d ec=%0d cc=%0d expected zeros",
                               vend_valid, error, change_valid, vend_product, err_code, change_coin);
        end
    endtask

    task automatic test_vend_basic();
        insert(2'd3); insert(2'd3); insert(2'd3);
        checks++;
        if (credit !== 8'd75) begin errors++; $display("FAIL three_quarters: got %0d expected 75", credit); end
        buy = 1'b1; product = 2'd0;
        tick();
        checks++;
        if (vend_valid !== 1'b1 || vend_product !== 2'd0 || credit !== 8'd10 || error !== 1'b0) begin
            errors++; $display("FAIL buy_p0: got vv=%0b vp=%0d credit=%0d err=%0b expected 1/0/10/0",
                               vend_valid, vend_product, credit, error);
        end
        tick();
        checks++;
        if (vend_valid !== 1'b0) begin errors++; $display("FAIL vend_pulse: got %0b expected 0", vend_valid); end
    endtask

    task automatic test_cancel();
        logic [1:0] exp_coin [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        logic [7:0] exp_cred [4] = '{8'd16, 8'd6, 8'd1, 8'd0};
        cancel = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || credit !== 8'd10 || change_valid !== 1'b0) begin
            errors++; $display("FAIL cancel_10_enter: got busy=%0b credit=%0d cv=%0b expected 1/10/0", busy, credit, change_valid);
        end
        tick();
        checks++;
        if (change_valid !== 1'b1 || change_coin !== 2'd2 || credit !== 8'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL cancel_10_dime: got cv=%0b cc=%0d credit=%0d busy=%0b expected 1/2/0/0",
                               change_valid, change_coin, credit, busy);
        end
        insert(2'd3); insert(2'd2); insert(2'd1); insert(2'd0);
        cancel = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || credit !== 8'd41) begin
            errors++; $display("FAIL cancel_41_enter: got busy=%0b credit=%0d expected 1/41", busy, credit);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (change_valid !== 1'b1 || change_coin !== exp_coin[i] || credit !== exp_cred[i] || busy !== (i < 3)) begin
                errors++; $display("FAIL change_41_step%0d: got cv=%0b cc=%0d credit=%0d busy=%0b expected 1/%0d/%0d/%0b",
                                   i, change_valid, change_coin, credit, busy, exp_coin[i], exp_cred[i], i < 3);
            end
        end
    endtask

    task automatic test_errors();
        do_reset();
        insert(2'd3); insert(2'd3);
        buy = 1'b1; product = 2'd3;
        tick();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd3 || credit !== 8'd50 || vend_valid !== 1'b0) begin
            errors++; $display("FAIL no_credit: got err=%0b code=%0d credit=%0d vv=%0b expected 1/3/50/0",
                               error, err_code, credit, vend_valid);
        end
        b_buy = 1'b1; b_product = 3'd5;
        tick();
        checks++;
        if (b_error !== 1'b1 || b_err_code !== 3'd1 || b_vend_valid !== 1'b0) begin
            errors++; $display("FAIL bad_product_5: got err=%0b code=%0d vv=%0b expected 1/1/0", b_error, b_err_code, b_vend_valid);
        end
        b_buy = 1'b1; b_product = 3'd7;
        tick();
        checks++;
        if (b_err_code !== 3'd1) begin errors++; $display("FAIL bad_product_7: got code=%0d expected 1", b_err_code); end
        b_coin_valid = 1'b1; b_coin_type = 2'd3;
        tick();
        b_buy = 1'b1; b_product = 3'd4;
        tick();
        checks++;
        if (b_vend_valid !== 1'b1 || b_vend_product !== 3'd4 || b_credit !== 8'd0 || b_error !== 1'b0) begin
            errors++; $display("FAIL last_product: got vv=%0b vp=%0d credit=%0d err=%0b expected 1/4/0/0",
                               b_vend_valid, b_vend_product, b_credit, b_error);
        end
    endtask

    task automatic test_sold_out();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            insert(2'd3); insert(2'd3);
            buy = 1'b1; product = 2'd1;
            tick();
            checks++;
            if (i < 5) begin
                if (vend_valid !== 1'b1 || vend_product !== 2'd1 || credit !== 8'd0) begin
                    errors++; $display("FAIL stock_buy%0d: got vv=%0b vp=%0d credit=%0d expected 1/1/0", i, vend_valid, vend_product, credit);
                end
            end else begin
                if (vend_valid !== 1'b0 || err_code !== 3'd2 || credit !== 8'd50) begin
                    errors++; $display("FAIL sold_out: got vv=%0b code=%0d credit=%0d expected 0/2/50", vend_valid, err_code, credit);
                end
            end
        end
        restock = 1'b1;
        tick();
        buy = 1'b1; product = 2'd1;
        tick();
        checks++;
        if (vend_valid !== 1'b1 || credit !== 8'd0 || error !== 1'b0) begin
            errors++; $display("FAIL after_restock: got vv=%0b credit=%0d err=%0b expected 1/0/0", vend_valid, credit, error);
        end
    endtask

    task automatic test_coin_reject();
        do_reset();
        for (int i = 0; i < 7; i++) insert(2'd3);
        insert(2'd2); insert(2'd1);
        insert(2'd3);
        checks++;
        if (error !== 1'b1 || err_code !== 3'd5 || change_valid !== 1'b1 || change_coin !== 2'd3 || credit !== 8'd190) begin
            errors++; $display("FAIL coin_reject: got err=%0b code=%0d cv=%0b cc=%0d credit=%0d expected 1/5/1/3/190",
                               error, err_code, change_valid, change_coin, credit);
        end
        insert(2'd2);
        checks++;
        if (credit !== 8'd200 || error !== 1'b0) begin
            errors++; $display("FAIL credit_at_max: got credit=%0d err=%0b expected 200/0", credit, error);
        end
        cancel = 1'b1;
        tick();
        tick();
        checks++;
        if (change_coin !== 2'd3 || credit !== 8'd175 || busy !== 1'b1) begin
            errors++; $display("FAIL refund_first: got cc=%0d credit=%0d busy=%0b expected 3/175/1", change_coin, credit, busy);
        end
        insert(2'd0);
        checks++;
        if (err_code !== 3'd5 || change_valid !== 1'b1 || change_coin !== 2'd0 || credit !== 8'd175 || busy !== 1'b1) begin
            errors++; $display("FAIL coin_in_change: got code=%0d cv=%0b cc=%0d credit=%0d busy=%0b expected 5/1/0/175/1",
                               err_code, change_valid, change_coin, credit, busy);
        end
        tick();
        checks++;
        if (change_coin !== 2'd3 || credit !== 8'd150 || error !== 1'b0) begin
            errors++; $display("FAIL refund_resume: got cc=%0d credit=%0d err=%0b expected 3/150/0", change_coin, credit, error);
        end
        do_reset();
        checks++;
        if (credit !== 8'd0 || busy !== 1'b0 || change_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_refund: got credit=%0d busy=%0b cv=%0b expected 0/0/0", credit, busy, change_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        insert(2'd3); insert(2'd3);
        buy = 1'b1; product = 2'd1; coin_valid = 1'b1; coin_type = 2'd3;
        tick();
        checks++;
        if (vend_valid !== 1'b1 || vend_product !== 2'd1 || credit !== 8'd25 || error !== 1'b0) begin
            errors++; $display("FAIL buy_plus_coin: got vv=%0b vp=%0d credit=%0d err=%0b expected 1/1/25/0",
                               vend_valid, vend_product, credit, error);
        end
        cancel = 1'b1; buy = 1'b1; product = 2'd0; coin_valid = 1'b1; coin_type = 2'd2;
        tick();
        checks++;
        if (error !== 1'b1 || err_code !== 3'd4 || vend_valid !== 1'b0 || busy !== 1'b1 || credit !== 8'd35) begin
            errors++; $display("FAIL cancel_plus_buy: got err=%0b code=%0d vv=%0b busy=%0b credit=%0d expected 1/4/0/1/35",
                               error, err_code, vend_valid, busy, credit);
        end
        buy = 1'b1; product = 2'd0;
        tick();
        checks++;
        if (err_code !== 3'd4 || change_valid !== 1'b1 || change_coin !== 2'd3 || credit !== 8'd10 || vend_valid !== 1'b0) begin
            errors++; $display("FAIL buy_in_change: got code=%0d cv=%0b cc=%0d credit=%0d vv=%0b expected 4/1/3/10/0",
                               err_code, change_valid, change_coin, credit, vend_valid);
        end
        tick();
        checks++;
        if (change_coin !== 2'd2 || credit !== 8'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL drain_end: got cc=%0d credit=%0d busy=%0b expected 2/0/0", change_coin, credit, busy);
        end
    endtask

    initial begin
        test_reset();
        test_vend_basic();
        test_cancel();
        test_errors();
        test_sold_out();
        test_coin_reject();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
